// File: rtl/dot_feed.sv
// dot_feed: buffers two Q8.8 operand vectors and replays them into a non-pipelined MAC.
// Optional macro FEED_SKIP_ZERO_EN: elements with a zero operand are skipped in one cycle.
module dot_feed #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 16,
  parameter int AW    = 4,
  parameter int GAP   = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ld_en,
  input  logic                    ld_sel,
  input  logic [AW-1:0]           ld_addr,
  input  logic [WIDTH-1:0]        ld_data,
  input  logic [AW-1:0]           len,
  input  logic                    start,
  output logic signed [WIDTH-1:0] A,
  output logic signed [WIDTH-1:0] B,
  output logic [3:0]              wrAddr,
  output logic                    busy,
  output logic                    done
);

  localparam int CW = $clog2(GAP + 1);
  localparam logic [3:0] CMD_IDLE  = 4'd0;
  localparam logic [3:0] CMD_LOAD  = 4'd1;
  localparam logic [3:0] CMD_CLEAR = 4'd2;

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic [AW-1:0]           idx, idx_nxt;
  logic [AW-1:0]           n, n_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic                    skipped, skip_nxt;
  logic signed [WIDTH-1:0] mem_a [DEPTH];
  logic signed [WIDTH-1:0] mem_b [DEPTH];
  logic signed [WIDTH-1:0] op_a, op_b;

  function automatic logic [AW-1:0] clamp_len(input logic [AW-1:0] l);
    return (l > AW'(DEPTH)) ? AW'(DEPTH) : l;
  endfunction

`ifdef FEED_SKIP_ZERO_EN
  function automatic logic has_zero(input logic signed [WIDTH-1:0] a,
                                    input logic signed [WIDTH-1:0] b);
    return (a == '0) || (b == '0);
  endfunction
`endif

  // Operand buffers are data only: no reset, writes locked out while a run is active.
  always_ff @(posedge clk) begin
    if (ld_en && !busy && (ld_addr < AW'(DEPTH))) begin
      if (ld_sel) mem_b[ld_addr] <= ld_data;
      else        mem_a[ld_addr] <= ld_data;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    n_nxt     = n;
    cnt_nxt   = cnt;
    unique case (state)
      S_IDLE: begin
        if (start && (len != '0)) begin
          state_nxt = S_CLR;
          n_nxt     = clamp_len(len);
          idx_nxt   = '0;
        end
      end
      S_CLR: state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (skipped) begin
          idx_nxt   = idx + 1'b1;
          state_nxt = (idx_nxt == n) ? S_DONE : S_ISSUE;
        end else begin
          state_nxt = S_WAIT;
          cnt_nxt   = CW'(GAP);
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          idx_nxt   = idx + 1'b1;
          state_nxt = (idx_nxt == n) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operands for the element about to be issued; outputs are registered from next state.
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (idx_nxt < AW'(DEPTH)) begin
      op_a = mem_a[idx_nxt];
      op_b = mem_b[idx_nxt];
    end
  end

`ifdef FEED_SKIP_ZERO_EN
  assign skip_nxt = (state_nxt == S_ISSUE) && has_zero(op_a, op_b);
`else
  assign skip_nxt = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      idx     <= '0;
      n       <= '0;
      cnt     <= '0;
      skipped <= 1'b0;
      A       <= '0;
      B       <= '0;
      wrAddr  <= CMD_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      n       <= n_nxt;
      cnt     <= cnt_nxt;
      skipped <= skip_nxt;
      busy    <= (state_nxt != S_IDLE);
      done    <= (state_nxt == S_DONE);
      wrAddr  <= CMD_IDLE;
      if (state_nxt == S_CLR) begin
        wrAddr <= CMD_CLEAR;
      end else if ((state_nxt == S_ISSUE) && !skip_nxt) begin
        wrAddr <= CMD_LOAD;
        A      <= op_a;
        B      <= op_b;
      end
    end
  end

endmodule
